// File: rtl/rsync_latch_pkg.sv
// Shared types and constants for the resync-latch power/clock sequencer.
package rsync_latch_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWRUP    = 3'd1,
    ST_CLK_ON   = 3'd2,
    ST_RUN      = 3'd3,
    ST_ATB_SCAN = 3'd4,
    ST_CLK_OFF  = 3'd5
  } state_t;

  localparam int NUM_THERM = 17;
  localparam int NUM_BIN   = 7;
  localparam int NUM_STEPS = NUM_THERM + NUM_BIN;

  localparam logic [4:0] FIRST_STEP = 5'd0;
  localparam logic [4:0] LAST_STEP  = 5'(NUM_STEPS - 1);

  localparam logic [1:0] ATB_OFF = 2'b00;
  localparam logic [1:0] ATB_0   = 2'b01;
  localparam logic [1:0] ATB_1   = 2'b10;
  localparam logic [1:0] ATB_2   = 2'b11;

endpackage

// File: rtl/rsync_clk_stagger.sv
// Staggered clock-enable shifter: one enable bit set or cleared per STAGGER_CYC,
// in step order, under up/down/hold control from the sequencer FSM.
module rsync_clk_stagger
  import rsync_latch_pkg::*;
#(
  parameter int STAGGER_CYC = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 start_up_i,
  input  logic                 up_i,
  input  logic                 start_down_i,
  input  logic                 down_i,
  output logic [NUM_STEPS-1:0] en_o,
  output logic [4:0]           idx_o,
  output logic                 tick_o
);

  localparam logic [5:0] TMR_LAST = 6'(STAGGER_CYC - 1);

  logic [NUM_STEPS-1:0] en_q, en_d;
  logic [4:0]           idx_q, idx_d, idx_up, idx_dn;
  logic [5:0]           tmr_q, tmr_d;

  assign idx_up = idx_q + 5'd1;
  assign idx_dn = idx_q - 5'd1;
  assign tick_o = (tmr_q == TMR_LAST);

  always_comb begin
    en_d  = en_q;
    idx_d = idx_q;
    tmr_d = tmr_q;
    if (clr_i) begin
      en_d  = '0;
      idx_d = FIRST_STEP;
      tmr_d = '0;
    end else if (start_up_i) begin
      en_d    = '0;
      en_d[0] = 1'b1;
      idx_d   = FIRST_STEP;
      tmr_d   = '0;
    end else if (start_down_i) begin
      // idx_q always points at the highest set step, so it clears first
      en_d[idx_q] = 1'b0;
      tmr_d       = '0;
    end else if (up_i) begin
      if (tick_o) begin
        tmr_d = '0;
        if (idx_q != LAST_STEP) begin
          idx_d        = idx_up;
          en_d[idx_up] = 1'b1;
        end
      end else begin
        tmr_d = tmr_q + 6'd1;
      end
    end else if (down_i && (idx_q != FIRST_STEP)) begin
      if (tick_o) begin
        tmr_d        = '0;
        idx_d        = idx_dn;
        en_d[idx_dn] = 1'b0;
      end else begin
        tmr_d = tmr_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q  <= '0;
      idx_q <= FIRST_STEP;
      tmr_q <= '0;
    end else begin
      en_q  <= en_d;
      idx_q <= idx_d;
      tmr_q <= tmr_d;
    end
  end

  assign en_o  = en_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/rsync_latch_seq.sv
// Power-up / clock-enable / ATB-scan sequencer for the resync latch.
// Handshake: en_req is a level (no ready); atb_scan_req is a one-cycle pulse honoured only in RUN.
module rsync_latch_seq
  import rsync_latch_pkg::*;
#(
  parameter int SETTLE_CYC  = 64,
  parameter int STAGGER_CYC = 4,
  parameter int DWELL_CYC   = 32
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 en_req,
  input  logic                 atb_scan_req,
  output logic                 pdb,
  output logic [NUM_THERM-1:0] clk_en_therm,
  output logic [NUM_BIN-1:0]   clk_en_bin,
  output logic [1:0]           atb_ena,
  output logic                 atb_sample,
  output logic                 ready,
  output logic                 busy,
  output logic [2:0]           dbg_state_o
);

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] DWELL_LAST  = 10'(DWELL_CYC - 1);

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] atb_q, atb_d;
  logic       smp_q, smp_d;
  logic       pdb_q, pdb_d;
  logic       rdy_q, rdy_d;
  logic       bsy_q, bsy_d;

  logic                 clr, start_up, up, start_down, down;
  logic [NUM_STEPS-1:0] en_vec;
  logic [4:0]           step_idx;
  logic                 step_tick;

  rsync_clk_stagger #(
    .STAGGER_CYC (STAGGER_CYC)
  ) u_stagger (
    .clk_i        (clkin),
    .rst_i        (rst),
    .clr_i        (clr),
    .start_up_i   (start_up),
    .up_i         (up),
    .start_down_i (start_down),
    .down_i       (down),
    .en_o         (en_vec),
    .idx_o        (step_idx),
    .tick_o       (step_tick)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    atb_d      = atb_q;
    clr        = 1'b0;
    start_up   = 1'b0;
    up         = 1'b0;
    start_down = 1'b0;
    down       = 1'b0;
    case (state_q)
      ST_OFF: begin
        clr   = 1'b1;
        cnt_d = '0;
        atb_d = ATB_OFF;
        if (en_req) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (!en_req) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d  = ST_CLK_ON;
          start_up = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_CLK_ON: begin
        if (!en_req) begin
          state_d    = ST_CLK_OFF;
          start_down = 1'b1;
        end else if (step_tick && (step_idx == LAST_STEP)) begin
          state_d = ST_RUN;
        end else begin
          up = 1'b1;
        end
      end
      ST_RUN: begin
        // a dropping en_req wins over a coincident scan request
        if (!en_req) begin
          state_d    = ST_CLK_OFF;
          start_down = 1'b1;
        end else if (atb_scan_req) begin
          state_d = ST_ATB_SCAN;
          atb_d   = ATB_0;
          cnt_d   = '0;
        end
      end
      ST_ATB_SCAN: begin
        if (!en_req) begin
          state_d    = ST_CLK_OFF;
          start_down = 1'b1;
          atb_d      = ATB_OFF;
          cnt_d      = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (atb_q == ATB_2) begin
            state_d = ST_RUN;
            atb_d   = ATB_OFF;
          end else begin
            atb_d = atb_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_CLK_OFF: begin
        if (step_idx == FIRST_STEP) state_d = ST_OFF;
        else                        down    = 1'b1;
      end
      default: state_d = ST_OFF;
    endcase

    // Outputs are decoded from the next state so they register with it
    smp_d = (state_d == ST_ATB_SCAN) && (cnt_d == DWELL_LAST);
    pdb_d = (state_d != ST_OFF);
    rdy_d = (state_d == ST_RUN);
    bsy_d = (state_d == ST_PWRUP) || (state_d == ST_CLK_ON) ||
            (state_d == ST_ATB_SCAN) || (state_d == ST_CLK_OFF);
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      atb_q   <= ATB_OFF;
      smp_q   <= 1'b0;
      pdb_q   <= 1'b0;
      rdy_q   <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      atb_q   <= atb_d;
      smp_q   <= smp_d;
      pdb_q   <= pdb_d;
      rdy_q   <= rdy_d;
      bsy_q   <= bsy_d;
    end
  end

  assign pdb          = pdb_q;
  assign clk_en_therm = en_vec[NUM_THERM-1:0];
  assign clk_en_bin   = en_vec[NUM_STEPS-1:NUM_THERM];
  assign atb_ena      = atb_q;
  assign atb_sample   = smp_q;
  assign ready        = rdy_q;
  assign busy         = bsy_q;
  assign dbg_state_o  = state_q;

endmodule
